serial_adder_ctrl: RTL and testbench

//  Bit-serial add sequencer around a single one-bit full adder cell.

---
 rtl/serial_adder_pkg.sv | 5 +
 rtl/serial_adder_ctrl_if.sv | 36 +++
 rtl/fulladder.sv | 11 +
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
    localparam int SA_MIN_WIDTH = 2;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// Macro SERIAL_ADDER_SUB_EN adds the sub_in operand-side signal.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_in;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             ovf_out;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        output sub_in,
`endif
        output out_ready,
        input  in_ready, out_valid, sum_out, carry_out, ovf_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub_in,
`endif
        input  out_ready,
        output in_ready, out_valid, sum_out, carry_out, ovf_out, busy
    );
endinterface

// File: rtl/fulladder.sv
// One-bit full adder cell: the only arithmetic in the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: LSB-first through one full adder, registered carry.
// Macro SERIAL_ADDER_SUB_EN enables subtraction via sub_in (A + ~B + 1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < SA_MIN_WIDTH) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH must be >= %0d", SA_MIN_WIDTH);
    end

    sa_state_t        state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic             carry_reg;
    logic             cmsb_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_out_reg;
    logic             carry_out_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic fa_sum;
    logic fa_carry;
    logic load_b_inv;
    logic load_carry;

    fulladder u_fa (
        .a     (a_sh_reg[0]),
        .b     (b_sh_reg[0]),
        .c     (carry_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is two's-complement: invert B and force carry-in high.
    assign load_b_inv = bus.sub_in;
    assign load_carry = bus.sub_in | bus.c_in;
`else
    assign load_b_inv = 1'b0;
    assign load_carry = bus.c_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_sh_reg    <= '0;
            carry_reg     <= 1'b0;
            cmsb_reg      <= 1'b0;
            cnt_reg       <= '0;
            sum_out_reg   <= '0;
            carry_out_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        a_sh_reg     <= bus.a_in;
                        b_sh_reg     <= load_b_inv ? ~bus.b_in : bus.b_in;
                        carry_reg    <= load_carry;
                        cnt_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    sum_sh_reg <= {fa_sum, sum_sh_reg[WIDTH-1:1]};
                    carry_reg  <= fa_carry;
                    // Carry produced by bit WIDTH-2 is the carry into the MSB.
                    if (cnt_reg == CNT_PRE) begin
                        cmsb_reg <= fa_carry;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        sum_out_reg   <= {fa_sum, sum_sh_reg[WIDTH-1:1]};
                        carry_out_reg <= fa_carry;
                        ovf_reg       <= cmsb_reg ^ fa_carry;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum_out   = sum_out_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.ovf_out   = ovf_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); SERIAL_ADDER_SUB_EN adds subtract vectors.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_carry;
        logic       exp_ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   acc_q[$];
    vec_t vecs[$];

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
        bus.a_in = a;
        bus.b_in = b;
        bus.c_in = c;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub_in = sub;
`else
        if (sub) $display("note: sub vector skipped without SERIAL_ADDER_SUB_EN");
`endif
    endtask

    // Waits up to max_cyc edges for out_valid; returns edges waited.
    task automatic wait_out(input int max_cyc, output int n);
        n = 0;
        while (!bus.out_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int n;
        drive_ops(v.a, v.b, v.c, v.sub);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_in_ready_run"}, {31'd0, bus.in_ready}, 32'd0);
        wait_out(40, n);
        check({tag, "_latency"}, n, WIDTH);
        check({tag, "_sum"}, {24'd0, bus.sum_out}, {24'd0, v.exp_sum});
        check({tag, "_carry"}, {31'd0, bus.carry_out}, {31'd0, v.exp_carry});
        check({tag, "_ovf"}, {31'd0, bus.ovf_out}, {31'd0, v.exp_ovf});
        $display("op %s a=%02h b=%02h c=%0d sub=%0d -> sum=%02h carry=%0d ovf=%0d latency=%0d",
                 tag, v.a, v.b, v.c, v.sub, bus.sum_out, bus.carry_out, bus.ovf_out, n);
        tick();
        check({tag, "_done_exit"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_in_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        vec_t v;
        checks = 0;
        errors = 0;

        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_ops(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_sum", {24'd0, bus.sum_out}, 32'd0);
        check("rst_carry_ovf", {30'd0, bus.carry_out, bus.ovf_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 5 cycles with a stray in_valid pulse.
        bus.out_ready = 1'b0;
        drive_ops(8'h7F, 8'h01, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out(40, n);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 2);
            drive_ops(8'h11, 8'h22, 1'b1, 1'b0);
            tick();
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_sum", {24'd0, bus.sum_out}, 32'h80);
            check("bp_flags", {30'd0, bus.carry_out, bus.ovf_out}, 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp_sum_held", {24'd0, bus.sum_out}, 32'h80);
        $display("op backpressure sum=%02h held through 5 stalled cycles", bus.sum_out);
        tick();
        check("bp_pulse_ignored", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset three cycles into RUN.
        drive_ops(8'hAA, 8'h0F, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("arst_sum", {24'd0, bus.sum_out}, 32'd0);
        $display("op async_reset mid-run: busy=%0d in_ready=%0d", bus.busy, bus.in_ready);
        tick();
        rst_n = 1'b1;
        tick();
        v = '{8'h10, 8'h22, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0};
        run_op(v, "post_rst");

        // Back-to-back: in_valid held, out_ready high, three acceptances.
        acc_q.delete();
        drive_ops(8'h01, 8'h02, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        n = 0;
        while (acc_q.size() < 3 && n < 60) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", acc_q.size(), 32'd3);
        if (acc_q.size() >= 3) begin
            check("b2b_gap1", acc_q[1] - acc_q[0], WIDTH + 2);
            check("b2b_gap2", acc_q[2] - acc_q[1], WIDTH + 2);
            $display("op back_to_back accepts at cycles %0d %0d %0d", acc_q[0], acc_q[1], acc_q[2]);
        end
        wait_out(40, n);
        check("b2b_sum", {24'd0, bus.sum_out}, 32'h03);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
